// File: rtl/telemetry_rx.sv
// telemetry_rx: 8N1 serial receiver plus frame parser for the telemetry link.
// Frame: 0xAA 0x55 {hi,lo} x3, where hi = {4'h0, v[11:8]} and lo = v[7:0].
// The three 12-bit values are published together with a one-cycle pkt_vld.
// frm_err pulses on a bad stop bit or on a payload high byte with a nonzero upper nibble.
module telemetry_rx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic [11:0] batt_v,
    output logic [11:0] avg_curr,
    output logic [11:0] avg_torque,
    output logic        pkt_vld,
    output logic        frm_err
);

    localparam int              CNT_W    = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HI
    } rx_state_t;

    typedef enum logic [1:0] {
        P_HUNT_AA,
        P_HUNT_55,
        P_PAY
    } p_state_t;

    // ------------------------------------------------------------------
    // RX synchroniser
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_s_q;

    // Two-flop synchroniser; both stages idle high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Byte receiver
    // ------------------------------------------------------------------
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_rdy_q, byte_rdy_d;
    logic             stop_err_d;
    logic             tick;

    // The counter is loaded with N and the sample is taken on the cycle it reads 1,
    // so a load of N places the sample exactly N cycles after the load decision.
    assign tick = (cnt_q <= CNT_ONE);

    // Receiver state, bit timer, shift register and byte strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            byte_rdy_q <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            byte_rdy_q <= byte_rdy_d;
        end
    end

    // Receiver next-state: mid-bit sampling, LSB first, stop-bit validation.
    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_rdy_d = 1'b0;
        stop_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = CNT_HALF;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_s_q) begin
                        // Line went back high before mid-bit: treat as a glitch.
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        cnt_d      = CNT_FULL;
                        bit_cnt_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RX_DATA: begin
                if (tick) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    cnt_d     = CNT_FULL;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (rx_s_q) begin
                        byte_rdy_d = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        // Break or misaligned stream: wait for the line to recover.
                        stop_err_d = 1'b1;
                        rx_state_d = RX_WAIT_HI;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RX_WAIT_HI: begin
                if (rx_s_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Frame parser
    // ------------------------------------------------------------------
    p_state_t   p_state_q, p_state_d;
    logic [2:0] idx_q, idx_d;
    logic       pkt_vld_d;
    logic       nib_err_d;
    logic       pay_wr;
    logic [7:0] rx_byte;

    // shift_q only changes in DATA, so it still holds the finished byte while byte_rdy_q is high.
    assign rx_byte = shift_q;
    assign pay_wr  = byte_rdy_q && (p_state_q == P_PAY);

    // Parser state and payload index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_state_q <= P_HUNT_AA;
            idx_q     <= '0;
        end else begin
            p_state_q <= p_state_d;
            idx_q     <= idx_d;
        end
    end

    // Parser next-state: delimiter hunt with 0xAA resync, payload walk, nibble check.
    always_comb begin
        p_state_d = p_state_q;
        idx_d     = idx_q;
        pkt_vld_d = 1'b0;
        nib_err_d = 1'b0;
        if (stop_err_d) begin
            // A framing error invalidates any frame in progress.
            p_state_d = P_HUNT_AA;
            idx_d     = '0;
        end else if (byte_rdy_q) begin
            case (p_state_q)
                P_HUNT_AA: begin
                    if (rx_byte == 8'hAA) begin
                        p_state_d = P_HUNT_55;
                    end
                end
                P_HUNT_55: begin
                    if (rx_byte == 8'h55) begin
                        p_state_d = P_PAY;
                        idx_d     = '0;
                    end else if (rx_byte != 8'hAA) begin
                        p_state_d = P_HUNT_AA;
                    end
                end
                P_PAY: begin
                    if (!idx_q[0] && (rx_byte[7:4] != 4'h0)) begin
                        nib_err_d = 1'b1;
                        p_state_d = P_HUNT_AA;
                        idx_d     = '0;
                    end else if (idx_q == 3'd5) begin
                        pkt_vld_d = 1'b1;
                        p_state_d = P_HUNT_AA;
                        idx_d     = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                default: begin
                    p_state_d = P_HUNT_AA;
                    idx_d     = '0;
                end
            endcase
        end
    end

    // One shadow value per output; high byte lands in [11:8], low byte in [7:0].
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_shadow
            localparam logic [2:0] HI_IDX = 3'(2 * gi);
            localparam logic [2:0] LO_IDX = 3'(2 * gi + 1);
            logic [11:0] sh_q;
            logic [11:0] sh_d;

            // Merge the incoming payload byte into this value when its slot comes up.
            always_comb begin
                sh_d = sh_q;
                if (pay_wr) begin
                    if (idx_q == HI_IDX) begin
                        sh_d[11:8] = rx_byte[3:0];
                    end else if (idx_q == LO_IDX) begin
                        sh_d[7:0] = rx_byte;
                    end
                end
            end

            // Shadow storage; only copied to the outputs once the whole frame checks out.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sh_q <= '0;
                end else begin
                    sh_q <= sh_d;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic [11:0] batt_v_q, avg_curr_q, avg_torque_q;
    logic        pkt_vld_q, frm_err_q;

    // Atomic update of all three values plus the registered strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            batt_v_q     <= '0;
            avg_curr_q   <= '0;
            avg_torque_q <= '0;
            pkt_vld_q    <= 1'b0;
            frm_err_q    <= 1'b0;
        end else begin
            if (pkt_vld_d) begin
                // The last low byte is still in flight, so take the merged next values.
                batt_v_q     <= g_shadow[0].sh_d;
                avg_curr_q   <= g_shadow[1].sh_d;
                avg_torque_q <= g_shadow[2].sh_d;
            end
            pkt_vld_q <= pkt_vld_d;
            frm_err_q <= stop_err_d | nib_err_d;
        end
    end

    assign batt_v     = batt_v_q;
    assign avg_curr   = avg_curr_q;
    assign avg_torque = avg_torque_q;
    assign pkt_vld    = pkt_vld_q;
    assign frm_err    = frm_err_q;

endmodule

// File: tb/tb_telemetry_rx.sv
// tb_telemetry_rx: directed frame vectors plus hand-written corner sequences.
module tb_telemetry_rx;

    localparam int B       = 16;
    localparam int H       = B / 2;
    // Cycles from driving a start bit low to pkt_vld / nibble frm_err (2 sync + 1 + H + 9B + 1)
    localparam int LAT_RDY  = 4 + H + 9 * B;
    // Cycles from driving a start bit low to a stop-bit frm_err
    localparam int LAT_STOP = 3 + H + 9 * B;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic [11:0] batt_v, avg_curr, avg_torque;
    logic        pkt_vld, frm_err;

    telemetry_rx #(.BAUD_DIV(B)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .batt_v     (batt_v),
        .avg_curr   (avg_curr),
        .avg_torque (avg_torque),
        .pkt_vld    (pkt_vld),
        .frm_err    (frm_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    int   pkt_cnt = 0, err_cnt = 0, pkt_cyc = -1, err_cyc = -1, viol = 0;
    logic pkt_prev = 1'b0, err_prev = 1'b0;
    always @(negedge clk) begin
        pkt_prev <= pkt_vld;
        err_prev <= frm_err;
        if (pkt_vld === 1'b1) begin
            pkt_cnt <= pkt_cnt + 1;
            pkt_cyc <= cyc;
        end
        if (frm_err === 1'b1) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if ((pkt_vld && pkt_prev) || (frm_err && err_prev) || (pkt_vld && frm_err))
            viol <= viol + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_vals(input string name, input logic [11:0] bv, input logic [11:0] ac,
                            input logic [11:0] at);
        chk({name, ".batt_v"}, int'(batt_v), int'(bv));
        chk({name, ".avg_curr"}, int'(avg_curr), int'(ac));
        chk({name, ".avg_torque"}, int'(avg_torque), int'(at));
    endtask

    task automatic send_bit(input logic v, input int n);
        @(posedge clk);
        #1;
        RX = v;
        repeat (n - 1) @(posedge clk);
    endtask

    int last_n0 = 0;
    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(posedge clk);
        #1;
        last_n0 = cyc;
        RX = 1'b0;
        repeat (B - 1) @(posedge clk);
        for (int k = 0; k < 8; k++) send_bit(b[k], B);
        send_bit(stop, B);
    endtask

    task automatic send_frame(input logic [11:0] bv, input logic [11:0] ac, input logic [11:0] at);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte({4'h0, bv[11:8]}, 1'b1);
        send_byte(bv[7:0], 1'b1);
        send_byte({4'h0, ac[11:8]}, 1'b1);
        send_byte(ac[7:0], 1'b1);
        send_byte({4'h0, at[11:8]}, 1'b1);
        send_byte(at[7:0], 1'b1);
    endtask

    typedef struct {
        logic [63:0] bytes;
        int          exp_pkt;
        int          exp_err;
        int          err_byte;
        logic [11:0] bv;
        logic [11:0] ac;
        logic [11:0] at;
    } vec_t;

    vec_t vecs[6];
    int   n0s[8];
    int   p0, e0;
    logic [11:0] rv0, rv1, rv2;

    initial begin
        vecs[0] = '{bytes: 64'hAA55_0ABC_0123_0FFF, exp_pkt: 1, exp_err: 0, err_byte: 0,
                    bv: 12'hABC, ac: 12'h123, at: 12'hFFF};
        vecs[1] = '{bytes: 64'hAA55_0000_0FFF_0000, exp_pkt: 1, exp_err: 0, err_byte: 0,
                    bv: 12'h000, ac: 12'hFFF, at: 12'h000};
        vecs[2] = '{bytes: 64'hAA55_1ABC_0123_0FFF, exp_pkt: 0, exp_err: 1, err_byte: 2,
                    bv: 12'h000, ac: 12'hFFF, at: 12'h000};
        vecs[3] = '{bytes: 64'hAA55_0FFF_0000_0FFF, exp_pkt: 1, exp_err: 0, err_byte: 0,
                    bv: 12'hFFF, ac: 12'h000, at: 12'hFFF};
        vecs[4] = '{bytes: 64'hAA55_0102_0304_5006, exp_pkt: 0, exp_err: 1, err_byte: 6,
                    bv: 12'hFFF, ac: 12'h000, at: 12'hFFF};
        vecs[5] = '{bytes: 64'hAA55_0123_0456_0789, exp_pkt: 1, exp_err: 0, err_byte: 0,
                    bv: 12'h123, ac: 12'h456, at: 12'h789};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_vals("reset", 12'h000, 12'h000, 12'h000);
        chk("reset.pkt_vld", int'(pkt_vld), 0);
        chk("reset.frm_err", int'(frm_err), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_bit(1'b1, 2 * B);

        // Table-driven back-to-back frames
        for (int v = 0; v < 6; v++) begin
            p0 = pkt_cnt;
            e0 = err_cnt;
            for (int i = 0; i < 8; i++) begin
                send_byte(vecs[v].bytes[63 - 8 * i -: 8], 1'b1);
                n0s[i] = last_n0;
            end
            send_bit(1'b1, B);
            @(negedge clk);
            $display("vec %0d: bytes=%h pkts=%0d errs=%0d batt_v=%h avg_curr=%h avg_torque=%h",
                     v, vecs[v].bytes, pkt_cnt - p0, err_cnt - e0, batt_v, avg_curr, avg_torque);
            chk($sformatf("vec%0d.pkt_count", v), pkt_cnt - p0, vecs[v].exp_pkt);
            chk($sformatf("vec%0d.err_count", v), err_cnt - e0, vecs[v].exp_err);
            chk_vals($sformatf("vec%0d", v), vecs[v].bv, vecs[v].ac, vecs[v].at);
            if (vecs[v].exp_pkt != 0)
                chk($sformatf("vec%0d.pkt_cycle", v), pkt_cyc, n0s[7] + LAT_RDY);
            if (vecs[v].exp_err != 0)
                chk($sformatf("vec%0d.err_cycle", v), err_cyc, n0s[vecs[v].err_byte] + LAT_RDY);
        end

        // Noise bytes and repeated 0xAA before the delimiter
        p0 = pkt_cnt;
        e0 = err_cnt;
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h03, 1'b1);
        send_bit(1'b1, B);
        @(negedge clk);
        $display("resync: pkts=%0d errs=%0d batt_v=%h avg_curr=%h avg_torque=%h",
                 pkt_cnt - p0, err_cnt - e0, batt_v, avg_curr, avg_torque);
        chk("resync.pkt_count", pkt_cnt - p0, 1);
        chk("resync.err_count", err_cnt - e0, 0);
        chk_vals("resync", 12'h001, 12'h002, 12'h003);

        // Stop-bit error on byte 4 followed by a long low line
        p0 = pkt_cnt;
        e0 = err_cnt;
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b0);
        send_bit(1'b0, 40);
        send_bit(1'b1, 2 * B);
        @(negedge clk);
        $display("stop_err: pkts=%0d errs=%0d batt_v=%h", pkt_cnt - p0, err_cnt - e0, batt_v);
        chk("stop_err.err_count", err_cnt - e0, 1);
        chk("stop_err.err_cycle", err_cyc, last_n0 + LAT_STOP);
        chk("stop_err.pkt_count", pkt_cnt - p0, 0);
        chk_vals("stop_err.hold", 12'h001, 12'h002, 12'h003);
        send_frame(12'h321, 12'h07F, 12'hC00);
        send_bit(1'b1, B);
        @(negedge clk);
        $display("after_stop_err: pkts=%0d errs=%0d batt_v=%h avg_curr=%h avg_torque=%h",
                 pkt_cnt - p0, err_cnt - e0, batt_v, avg_curr, avg_torque);
        chk("after_stop_err.pkt_count", pkt_cnt - p0, 1);
        chk("after_stop_err.err_count", err_cnt - e0, 1);
        chk_vals("after_stop_err", 12'h321, 12'h07F, 12'hC00);

        // 3-cycle glitch inside a frame must not produce a byte
        p0 = pkt_cnt;
        e0 = err_cnt;
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_bit(1'b0, 3);
        send_bit(1'b1, 2 * B);
        send_byte(8'h0A, 1'b1);
        send_byte(8'hBC, 1'b1);
        send_byte(8'h0D, 1'b1);
        send_byte(8'hEF, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_bit(1'b1, B);
        @(negedge clk);
        $display("glitch: pkts=%0d errs=%0d batt_v=%h avg_curr=%h avg_torque=%h",
                 pkt_cnt - p0, err_cnt - e0, batt_v, avg_curr, avg_torque);
        chk("glitch.pkt_count", pkt_cnt - p0, 1);
        chk("glitch.err_count", err_cnt - e0, 0);
        chk_vals("glitch", 12'hABC, 12'hDEF, 12'h100);

        // Reset after byte 5 of a frame
        p0 = pkt_cnt;
        e0 = err_cnt;
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_bit(1'b1, 4);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        $display("mid_reset: batt_v=%h avg_curr=%h avg_torque=%h", batt_v, avg_curr, avg_torque);
        chk_vals("mid_reset", 12'h000, 12'h000, 12'h000);
        send_byte(8'h04, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h06, 1'b1);
        send_bit(1'b1, B);
        @(negedge clk);
        chk("mid_reset.tail_pkt_count", pkt_cnt - p0, 0);
        chk("mid_reset.err_count", err_cnt - e0, 0);
        send_frame(12'h456, 12'h789, 12'hABC);
        send_bit(1'b1, B);
        @(negedge clk);
        $display("after_reset: pkts=%0d batt_v=%h avg_curr=%h avg_torque=%h",
                 pkt_cnt - p0, batt_v, avg_curr, avg_torque);
        chk("after_reset.pkt_count", pkt_cnt - p0, 1);
        chk_vals("after_reset", 12'h456, 12'h789, 12'hABC);

        // Transmitter-style frames with idle gaps, including extremes
        for (int f = 0; f < 4; f++) begin
            if (f == 0) begin
                rv0 = 12'h000; rv1 = 12'hFFF; rv2 = 12'h000;
            end else if (f == 1) begin
                rv0 = 12'hFFF; rv1 = 12'h000; rv2 = 12'hFFF;
            end else begin
                rv0 = 12'($urandom_range(0, 4095));
                rv1 = 12'($urandom_range(0, 4095));
                rv2 = 12'($urandom_range(0, 4095));
            end
            p0 = pkt_cnt;
            e0 = err_cnt;
            send_frame(rv0, rv1, rv2);
            send_bit(1'b1, 1 + $urandom_range(0, 3 * B));
            @(negedge clk);
            $display("loop %0d: pkts=%0d errs=%0d batt_v=%h avg_curr=%h avg_torque=%h",
                     f, pkt_cnt - p0, err_cnt - e0, batt_v, avg_curr, avg_torque);
            chk($sformatf("loop%0d.pkt_count", f), pkt_cnt - p0, 1);
            chk($sformatf("loop%0d.err_count", f), err_cnt - e0, 0);
            chk_vals($sformatf("loop%0d", f), rv0, rv1, rv2);
        end

        @(negedge clk);
        chk("pulse_shape_violations", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/telemetry_rx.md
# telemetry_rx

Serial receiver and packet parser for the 8-byte telemetry frame produced by the telemetry transmitter: 0xAA, 0x55, then batt_v, avg_curr, avg_torque, each sent as a high byte {4'h0, v[11:8]} followed by a low byte v[7:0]. It sits directly downstream of the transmitter's TX line, either on the bench side or in a loop-back test harness. It recovers bytes from the 8N1 serial stream, locks onto the delimiter pair and validates each frame. It presents the three 12-bit values with a one-cycle valid strobe.

## Interface
- BAUD_DIV, 2604: clk cycles per bit; must match the transmitter's bit period. Minimum value is 4.
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- RX  in  1  serial line, idle high; asynchronous to clk.
- batt_v  out  12  battery voltage from the last good frame.
- avg_curr  out  12  average current from the last good frame.
- avg_torque  out  12  average torque from the last good frame.
- pkt_vld  out  1  one-cycle pulse; the three value outputs were just updated.
- frm_err  out  1  one-cycle pulse on a stop-bit error or a bad payload high nibble.

## Operation
- **RX synchroniser:** RX passes through 2 flops that reset to 1, giving rx_s. All logic uses only rx_s.
- **Byte receiver FSM states:** IDLE, START, DATA, STOP, WAIT_HI.
  - IDLE: when rx_s is low, go to START and load the baud counter with BAUD_DIV/2 (integer divide).
  - START: when the counter expires, sample rx_s.
    - 1: false start; return to IDLE with no error.
    - 0: go to DATA and reload the counter with BAUD_DIV.
  - DATA: sample 8 bits, LSB first, one at each counter expiry, reloading BAUD_DIV each time; then go to STOP.
  - STOP: on counter expiry, sample rx_s.
    - 1: the byte is complete. Raise internal byte_rdy for 1 cycle and go to IDLE.
    - 0: framing error. Pulse frm_err, drop the byte, reset the parser to HUNT_AA, and go to WAIT_HI.
  - WAIT_HI: stay until rx_s is 1, then go to IDLE.
- **Parser FSM states:** HUNT_AA, HUNT_55, PAY with a 3-bit index 0..5. It advances only on byte_rdy.
  - HUNT_AA: byte 0xAA goes to HUNT_55; any other byte stays in HUNT_AA.
  - HUNT_55: byte 0x55 goes to PAY with idx=0; byte 0xAA stays in HUNT_55 (resync); any other byte goes to HUNT_AA.
  - PAY: store the byte in shadow register idx.
    - For even idx (high bytes), byte[7:4] must equal 0. Otherwise pulse frm_err, discard the shadow registers and go to HUNT_AA.
    - idx=5 accepted: load all three outputs together from the shadow registers, pulse pkt_vld and go to HUNT_AA.
- **Outputs:** values change only when a complete, valid frame is received. There is no partial update. Between frames the outputs hold.
- **Output composition:** each output is {high_byte[3:0], low_byte[7:0]}, so each is exactly 12 bits with no extension or truncation.
- **Reset values:** all outputs are 0. The receiver resets to IDLE, the parser to HUNT_AA, and the counter and shift register to 0.
  - Reset takes effect on the next clk edge even mid-byte or mid-frame. The partial frame is lost and no pulse is emitted.

## Timing
- **Byte sample points:** let t0 be the first cycle rx_s is low in IDLE.
  - The start bit is sampled at t0+BAUD_DIV/2.
  - Bit k is sampled at t0+BAUD_DIV/2+(k+1)*BAUD_DIV.
  - The stop bit is sampled at t0+BAUD_DIV/2+9*BAUD_DIV.
- **byte_rdy:** registered, high in the cycle after the stop-bit sample.
- **pkt_vld:** high in the cycle after the byte_rdy of byte 8. The new output values are visible in that same cycle.
- **frm_err:** a stop-bit error pulses in the cycle after the bad stop-bit sample. A bad high nibble pulses in the cycle after that byte's byte_rdy.
- **Back-to-back bytes:** the receiver re-arms in IDLE on the cycle after a good stop sample. Back-to-back bytes with no idle gap are received correctly.
- **Pulse width:** pkt_vld and frm_err are each exactly 1 cycle wide and never overlap.
- **Tolerance:** sampling at mid-bit tolerates ±4% baud mismatch.
- **Gaps between frames:** no timeout. An arbitrary idle gap inside a frame is legal.

## Test plan
- **Good frame:** BAUD_DIV=16, frame AA 55 0A BC 01 23 0F FF -> one pkt_vld; batt_v=0xABC, avg_curr=0x123, avg_torque=0xFFF; frm_err never high.
- **Resync and noise:** send 12 34 AA AA 55 then a valid payload 00 01 00 02 00 03 -> exactly one pkt_vld, values 0x001/0x002/0x003. The noise bytes produce no pkt_vld.
- **Bad high nibble:** AA 55 1A BC ... (bad high nibble) -> frm_err pulse 1 cycle after byte 3; outputs keep their previous values; no pkt_vld. A following valid frame is accepted.
- **Stop-bit error and glitch:**
  - Drive stop bit 0 on byte 4, then hold RX low for 40 cycles -> single frm_err; receiver waits for RX high; next frame is accepted.
  - A 3-cycle low glitch -> treated as a false start; no byte and no error.
- **Reset mid-frame:** assert rst_n low for 1 cycle after byte 5 -> all outputs 0; the remaining bytes produce no pkt_vld; the next full frame is received normally.
- **Loop-back:** connect the telemetry transmitter's TX to RX with BAUD_DIV matched -> pkt_vld about once per transmitter period. Outputs equal the transmitter's batt_v/avg_curr/avg_torque inputs, including 0x000 and 0xFFF.
